// File: rtl/reg_update_scheduler_pkg.sv
// rtl/reg_update_scheduler_pkg.sv - shared FSM encoding and entry layout for reg_update_scheduler
package reg_update_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_NEXT  = 2'd2
  } sched_state_t;

  localparam int DEF_N_BLOCKS       = 32;
  localparam int DEF_REG_ADDR_WIDTH = 4;
  localparam int DEF_DATA_WIDTH     = 16;
  localparam int DEF_FIFO_DEPTH     = 8;
  localparam int DEF_MAX_PER_TICK   = 4;

  // Entries are packed as {block, reg, data} with data in the low bits.
  function automatic int entry_width(input int block_w, input int reg_w, input int data_w);
    return block_w + reg_w + data_w;
  endfunction

endpackage

// File: rtl/reg_update_fifo.sv
// rtl/reg_update_fifo.sv - pending-update FIFO; in-place coalescing under REG_UPDATE_COALESCE_EN
// Pointers wrap naturally because depth is a power of two.
module reg_update_fifo
  import reg_update_scheduler_pkg::*;
#(
  parameter int BLOCK_W = 5,
  parameter int REG_W   = DEF_REG_ADDR_WIDTH,
  parameter int DATA_W  = DEF_DATA_WIDTH,
  parameter int DEPTH   = DEF_FIFO_DEPTH,
  parameter int CNT_W   = $clog2(DEF_FIFO_DEPTH) + 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               flush,
  input  logic               push_valid,
  output logic               push_ready,
  input  logic [BLOCK_W-1:0] push_block,
  input  logic [REG_W-1:0]   push_reg,
  input  logic [DATA_W-1:0]  push_data,
  input  logic               pop,
  input  logic               protect_head,
  output logic [BLOCK_W-1:0] head_block,
  output logic [REG_W-1:0]   head_reg,
  output logic [DATA_W-1:0]  head_data,
  output logic [CNT_W-1:0]   count,
  output logic               empty
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int ENTRY_W = entry_width(BLOCK_W, REG_W, DATA_W);

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [CNT_W-1:0]   cnt;
  logic               full;
  logic               push_do;
  logic               write_new;
  logic               pop_do;
  logic               coalesce;
  logic [PTR_W-1:0]   match_idx;

  assign full  = (cnt == CNT_W'(DEPTH));
  assign empty = (cnt == '0);
  assign count = cnt;

  assign head_block = mem[rd_ptr][ENTRY_W-1:REG_W+DATA_W];
  assign head_reg   = mem[rd_ptr][REG_W+DATA_W-1:DATA_W];
  assign head_data  = mem[rd_ptr][DATA_W-1:0];

`ifdef REG_UPDATE_COALESCE_EN
  logic match;

  // Scan in age order so the last hit is the newest pending copy of the key.
  always_comb begin
    logic [PTR_W-1:0] idx;
    match     = 1'b0;
    match_idx = '0;
    idx       = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr + PTR_W'(k);
      if ((CNT_W'(k) < cnt) && !(protect_head && (k == 0)) &&
          (mem[idx][ENTRY_W-1:DATA_W] == {push_block, push_reg})) begin
        match     = 1'b1;
        match_idx = idx;
      end
    end
  end

  assign push_ready = !full || match;
  assign coalesce   = push_valid && match && !flush;
`else
  logic unused_protect;
  assign unused_protect = protect_head;
  assign match_idx      = '0;
  assign push_ready     = !full;
  assign coalesce       = 1'b0;
`endif

  assign push_do   = push_valid && push_ready && !flush;
  assign write_new = push_do && !coalesce;
  assign pop_do    = pop && !empty && !flush;

  always_ff @(posedge clk) begin
    if (write_new) begin
      mem[wr_ptr] <= {push_block, push_reg, push_data};
    end
    if (coalesce) begin
      mem[match_idx][DATA_W-1:0] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (write_new) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_do)    rd_ptr <= rd_ptr + PTR_W'(1);
      case ({write_new, pop_do})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/reg_update_scheduler.sv
// rtl/reg_update_scheduler.sv - commits queued register updates only at sample boundaries
// Optional in-place coalescing of duplicate (block, reg) updates: REG_UPDATE_COALESCE_EN.
module reg_update_scheduler
  import reg_update_scheduler_pkg::*;
#(
  parameter int n_blocks       = DEF_N_BLOCKS,
  parameter int reg_addr_width = DEF_REG_ADDR_WIDTH,
  parameter int data_width     = DEF_DATA_WIDTH,
  parameter int fifo_depth     = DEF_FIFO_DEPTH,
  parameter int max_per_tick   = DEF_MAX_PER_TICK
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          upd_valid,
  output logic                          upd_ready,
  input  logic [$clog2(n_blocks)-1:0]   upd_block,
  input  logic [reg_addr_width-1:0]     upd_reg,
  input  logic [data_width-1:0]         upd_data,
  input  logic                          sample_tick,
  input  logic                          flush,
  output logic                          wr_en,
  output logic [$clog2(n_blocks)-1:0]   wr_block,
  output logic [reg_addr_width-1:0]     wr_reg,
  output logic [data_width-1:0]         wr_data,
  input  logic                          wr_ack,
  output logic                          batch_done,
  output logic [$clog2(fifo_depth):0]   fifo_count,
  output logic                          overflow
);

  localparam int BLOCK_W = $clog2(n_blocks);
  localparam int CNT_W   = $clog2(fifo_depth) + 1;
  localparam int BATCH_W = $clog2(max_per_tick + 1);

  sched_state_t          state;
  logic [BATCH_W-1:0]    batch_cnt;
  logic [BLOCK_W-1:0]    head_block;
  logic [reg_addr_width-1:0] head_reg;
  logic [data_width-1:0] head_data;
  logic                  empty;
  logic                  pop;
  logic                  protect_head;

  assign pop = (state == ST_ISSUE) && wr_ack && !flush;

  // The head is also shielded on the cycle it is being loaded into wr_*.
  assign protect_head = (state != ST_IDLE) || (sample_tick && !empty);

  reg_update_fifo #(
    .BLOCK_W (BLOCK_W),
    .REG_W   (reg_addr_width),
    .DATA_W  (data_width),
    .DEPTH   (fifo_depth),
    .CNT_W   (CNT_W)
  ) u_fifo (
    .clk          (clk),
    .reset_n      (reset_n),
    .flush        (flush),
    .push_valid   (upd_valid),
    .push_ready   (upd_ready),
    .push_block   (upd_block),
    .push_reg     (upd_reg),
    .push_data    (upd_data),
    .pop          (pop),
    .protect_head (protect_head),
    .head_block   (head_block),
    .head_reg     (head_reg),
    .head_data    (head_data),
    .count        (fifo_count),
    .empty        (empty)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow <= 1'b0;
    end else if (flush) begin
      overflow <= 1'b0;
    end else if (upd_valid && !upd_ready) begin
      overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      batch_cnt  <= '0;
      wr_en      <= 1'b0;
      wr_block   <= '0;
      wr_reg     <= '0;
      wr_data    <= '0;
      batch_done <= 1'b0;
    end else if (flush) begin
      state      <= ST_IDLE;
      batch_cnt  <= '0;
      wr_en      <= 1'b0;
      batch_done <= 1'b0;
    end else begin
      batch_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (sample_tick && !empty) begin
            wr_block  <= head_block;
            wr_reg    <= head_reg;
            wr_data   <= head_data;
            wr_en     <= 1'b1;
            batch_cnt <= '0;
            state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (wr_ack) begin
            wr_en     <= 1'b0;
            batch_cnt <= batch_cnt + BATCH_W'(1);
            state     <= ST_NEXT;
          end
        end
        ST_NEXT: begin
          if (!empty && (batch_cnt < BATCH_W'(max_per_tick))) begin
            wr_block <= head_block;
            wr_reg   <= head_reg;
            wr_data  <= head_data;
            wr_en    <= 1'b1;
            state    <= ST_ISSUE;
          end else begin
            batch_done <= 1'b1;
            state      <= ST_IDLE;
          end
        end
        default: begin
          wr_en <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
